// File: rtl/operand_bus_pkg.sv
// Shared types and constants for the two-requester ALU operand bus arbiter.
package operand_bus_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic SRC_REQ0 = 1'b0;
    localparam logic SRC_REQ1 = 1'b1;

endpackage

// File: rtl/word_mux2.sv
// Two-input word select feeding the operand output register.
module word_mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/operand_bus_arbiter.sv
// Round-robin arbiter sharing one operand bus between two requesters, with a
// one-entry output register held until the ALU consumes it.
module operand_bus_arbiter
    import operand_bus_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;
    logic             open_win;
    logic             grant0, grant1, xfer;
    logic [WIDTH-1:0] mux_word;

    // Readies are gated by rst_n so nothing is offered while reset is held.
    assign open_win = rst_n && ((state_q == EMPTY) || (state_q == FULL && out_ready));
    assign grant0   = open_win && req0_valid && (!req1_valid || last_grant_q == SRC_REQ1);
    assign grant1   = open_win && req1_valid && (!req0_valid || last_grant_q == SRC_REQ0);
    assign xfer     = grant0 || grant1;

    word_mux2 #(.WIDTH(WIDTH)) u_mux (
        .a_i   (req0_data),
        .b_i   (req1_data),
        .sel_i (grant1),
        .y_o   (mux_word)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;
        if (xfer) begin
            state_d      = FULL;
            out_data_d   = mux_word;
            out_src_d    = grant1 ? SRC_REQ1 : SRC_REQ0;
            last_grant_d = grant1 ? SRC_REQ1 : SRC_REQ0;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    // last_grant resets to req1 so the first tie goes to req0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= SRC_REQ1;
            out_data_q   <= '0;
            out_src_q    <= SRC_REQ0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign out_valid  = (state_q == FULL);
    assign out_data   = out_data_q;
    assign out_src    = out_src_q;

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Bench for operand_bus_arbiter: directed vector table, reset corner case and
// a randomized soak, all backed by a reference model and an in-order scoreboard.
module tb_operand_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data, out_data;
    logic        out_valid, out_src, out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_bus_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        ordy;
        logic        er0;
        logic        er1;
        logic        eov;
        logic [31:0] eod;
        logic        esrc;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        src;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    logic m_full;
    logic m_last;
    logic m_r0, m_r1;
    int   wait0, wait1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic [31:0] d0,
                                input logic v1, input logic [31:0] d1,
                                input logic ordy, input logic er0, input logic er1,
                                input logic eov, input logic [31:0] eod, input logic esrc);
        vec_t v;
        v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ordy = ordy;
        v.er0 = er0; v.er1 = er1; v.eov = eov; v.eod = eod; v.esrc = esrc;
        return v;
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_last = 1'b1;
        wait0  = 0;
        wait1  = 0;
        sbq.delete();
    endtask

    // Drive one cycle at the falling edge, check against the model, then advance the model.
    task automatic step(input logic v0, input logic [31:0] d0,
                        input logic v1, input logic [31:0] d1, input logic ordy);
        logic open_m;
        sb_t  e;
        sb_t  got;
        @(negedge clk);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        out_ready  = ordy;
        #1;
        open_m = !m_full || ordy;
        m_r0   = open_m && v0 && (!v1 || m_last);
        m_r1   = open_m && v1 && (!v0 || !m_last);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, m_r0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, m_r1});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        if (out_valid && ordy) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_data", out_data, e.data);
                chk("sb_src", {31'd0, out_src}, {31'd0, e.src});
            end
        end
        // Fairness: a continuously valid requester may lose at most once in a row.
        if (v0 && !req0_ready && req1_ready) wait0++; else if (req0_ready || !v0) wait0 = 0;
        if (v1 && !req1_ready && req0_ready) wait1++; else if (req1_ready || !v1) wait1 = 0;
        chk("fair0", {31'd0, wait0 <= 1}, 32'd1);
        chk("fair1", {31'd0, wait1 <= 1}, 32'd1);
        if (m_r0) begin
            got.data = d0; got.src = 1'b0; sbq.push_back(got);
            m_full = 1'b1; m_last = 1'b0;
        end else if (m_r1) begin
            got.data = d1; got.src = 1'b1; sbq.push_back(got);
            m_full = 1'b1; m_last = 1'b1;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] seq0, seq1;
        logic        rv0, rv1, rrdy;

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = 32'h1; req1_valid = 1'b1; req1_data = 32'h2;
        out_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_src", {31'd0, out_src}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Alternation under continuous contention: A0,B0,A1,B1.
        tbl.push_back(mk(1, 32'hA0, 1, 32'hB0, 1, 1, 0, 0, 32'h0,  0));
        tbl.push_back(mk(1, 32'hA1, 1, 32'hB0, 1, 0, 1, 1, 32'hA0, 0));
        tbl.push_back(mk(1, 32'hA1, 1, 32'hB1, 1, 1, 0, 1, 32'hB0, 1));
        tbl.push_back(mk(1, 32'hA2, 1, 32'hB1, 1, 0, 1, 1, 32'hA1, 0));
        tbl.push_back(mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 1, 32'hB1, 1));
        tbl.push_back(mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0));
        // Single requester.
        tbl.push_back(mk(1, 32'h11, 0, 32'h0,  1, 1, 0, 0, 32'h0,  0));
        tbl.push_back(mk(0, 32'h0,  0, 32'h0,  0, 0, 0, 1, 32'h11, 0));
        // Backpressure: refill with 0x55, then req1 stalls for three cycles.
        tbl.push_back(mk(1, 32'h55, 0, 32'h0,  1, 1, 0, 1, 32'h11, 0));
        tbl.push_back(mk(0, 32'h0,  1, 32'h77, 0, 0, 0, 1, 32'h55, 0));
        tbl.push_back(mk(0, 32'h0,  1, 32'h77, 0, 0, 0, 1, 32'h55, 0));
        tbl.push_back(mk(1, 32'h99, 1, 32'h77, 0, 0, 0, 1, 32'h55, 0));
        tbl.push_back(mk(0, 32'h0,  1, 32'h77, 1, 0, 1, 1, 32'h55, 0));
        tbl.push_back(mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 1, 32'h77, 1));
        // Drained; out_ready while EMPTY is ignored.
        tbl.push_back(mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0));
        tbl.push_back(mk(0, 32'h0,  0, 32'h0,  0, 0, 0, 0, 32'h0,  0));
        tbl.push_back(mk(0, 32'h0,  0, 32'h0,  1, 0, 0, 0, 32'h0,  0));

        foreach (tbl[i]) begin
            step(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].ordy);
            chk($sformatf("vec%0d_r0", i), {31'd0, req0_ready}, {31'd0, tbl[i].er0});
            chk($sformatf("vec%0d_r1", i), {31'd0, req1_ready}, {31'd0, tbl[i].er1});
            chk($sformatf("vec%0d_ov", i), {31'd0, out_valid}, {31'd0, tbl[i].eov});
            if (tbl[i].eov) begin
                chk($sformatf("vec%0d_od", i), out_data, tbl[i].eod);
                chk($sformatf("vec%0d_src", i), {31'd0, out_src}, {31'd0, tbl[i].esrc});
            end
        end

        // Asynchronous reset while FULL discards the held word.
        step(1, 32'hDEADBEEF, 0, 32'h0, 0);
        step(0, 32'h0, 0, 32'h0, 0);
        chk("pre_rst_data", out_data, 32'hDEADBEEF);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ov", {31'd0, out_valid}, 32'd0);
        chk("async_rst_od", out_data, 32'd0);
        chk("async_rst_r0", {31'd0, req0_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        step(1, 32'hC0, 1, 32'hD0, 1);
        chk("post_rst_tie_r0", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_tie_r1", {31'd0, req1_ready}, 32'd0);

        // Randomized soak.
        seq0 = 16'd1; seq1 = 16'd1;
        for (int c = 0; c < 10000; c++) begin
            rv0  = ($urandom_range(0, 9) < 7);
            rv1  = ($urandom_range(0, 9) < 7);
            rrdy = ($urandom_range(0, 9) < 6);
            step(rv0, {16'hA000, seq0}, rv1, {16'hB000, seq1}, rrdy);
            if (m_r0) seq0++;
            if (m_r1) seq1++;
        end
        for (int c = 0; c < 4; c++) step(0, 32'h0, 0, 32'h0, 1);
        chk("sb_drained", sbq.size(), 32'd0);
        chk("final_ov", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_bus_arbiter.md
# operand_bus_arbiter

- Shares one WIDTH-bit operand bus feeding the ALU between two requesters, e.g. the register-file read path and the forwarding/immediate path.
- Round-robin arbitration with a valid/ready handshake per requester.
- The winning word is captured into a one-entry output register, presented to the ALU with its source tag and held until the ALU accepts it.
- Sits between operand producers and the ALU input stage; it is the controller that drives the select of the bus multiplexer.

## Interface

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- out_valid  output  1  out_data holds an unconsumed word.
- out_data  output  WIDTH  registered operand to the ALU.
- out_src  output  1  source of out_data (0 = req0, 1 = req1).
- out_ready  input  1  ALU consumes out_data this cycle.

## Operation

- State machine with two states.
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- Accept window: open = (state == EMPTY) || (state == FULL && out_ready).
- Grant, evaluated only while open:
  - Only one requester valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - Neither valid: no grant.
- reqN_ready = open && grant == N. These signals are combinational from inputs and state; they never depend on reqN_data.
- A transfer occurs on a cycle where reqN_valid && reqN_ready. On the next edge:
  - out_data <= reqN_data.
  - out_src <= N.
  - last_grant <= N.
  - state <= FULL.
- Drain: FULL && out_ready with no new transfer -> EMPTY.
- Drain plus refill in the same cycle: state stays FULL and the new word replaces the old one. This allows back-to-back throughput of one word per cycle.
- FULL && !out_ready: out_data and out_src are held stable, and both reqN_ready are 0.
- The losing requester's valid stays asserted; it must win the next open cycle if the winner's valid is still asserted (fairness bound: one word of wait).
- No word is ever dropped or duplicated. Every transfer produces exactly one out_valid && out_ready beat, in order.

## Timing

Reset (asynchronous assertion, any cycle):
- state = EMPTY.
- out_valid = 0.
- out_data = 0.
- out_src = 0.
- last_grant = 1, so req0 wins the first tie.
- reqN_ready = 0 while rst_n is low.
- A held word is discarded by reset mid-operation.

Latency and throughput:
- Transfer-to-out_valid latency: 1 cycle.
- Sustained throughput: 1 word/cycle while out_ready = 1.
- With both requesters continuously valid and out_ready = 1, grants alternate 0,1,0,1…

Boundary cases:
- out_ready asserted while EMPTY: ignored.
- A requester that deasserts valid before being granted: no side effect.
- Reset release: first grant possible in the first cycle after rst_n rises.

## Structure

Shared package (operand_bus_pkg):
- WIDTH default.
- State encoding: EMPTY = 1'b0, FULL = 1'b1.
- Source tag constants: SRC_REQ0 = 1'b0, SRC_REQ1 = 1'b1.

Design split:
- One natural sub-module, word_mux2: the WIDTH-bit two-input data select driven by the grant.
- The top level holds:
  - grant logic;
  - last_grant register;
  - state register;
  - output register.

## Test plan

- Reset with rst_n = 0 mid-FULL (out_data = 0xDEADBEEF) -> immediately out_valid = 0 and out_data = 0; after release, first tie goes to req0.
- Only req0 valid with 0x00000011, out_ready = 1 -> req0_ready = 1 that cycle; next cycle out_valid = 1, out_data = 0x11, out_src = 0.
- Both valid every cycle with out_ready = 1:
  - stimulus: req0 sends 0xA0, 0xA1…; req1 sends 0xB0, 0xB1…;
  - response: out_data sequence is 0xA0, 0xB0, 0xA1, 0xB1 with out_src alternating 0,1,0,1.
- Backpressure: FULL with 0x55, out_ready = 0 for 3 cycles while req1 valid -> req1_ready = 0 and out_data = 0x55 for all 3 cycles; on the cycle out_ready = 1, req1_ready = 1, and next cycle shows req1's word.
- Drain without refill: FULL, out_ready = 1, no requester valid -> next cycle out_valid = 0; a later out_ready pulse changes nothing.
- Fairness randomized soak (10k cycles, random valids and out_ready) -> scoreboard shows no loss, no duplication, per-source order preserved, and no requester waits more than one grant while continuously valid.
